stream_demux: RTL

//  1-to-2 streaming demultiplexer for systolic-array operand routing. It is the counterpart of the 2:1 8-bit operand mux.

---
 rtl/stream_demux_pkg.sv | 25 ++
 rtl/stream_fifo.sv | 75 +++++++
 rtl/stream_demux.sv | 110 +++++++++++
 3 files changed

// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the stream demultiplexer.
//   rr_state_t : round-robin FSM state, encoded as the lane it targets
//   LANE0/LANE1: lane identifiers used for steering
//   clog2      : ceil(log2(value)), used to size pointers and counters
package stream_demux_pkg;

  typedef enum logic {
    RR_LANE0 = 1'b0,
    RR_LANE1 = 1'b1
  } rr_state_t;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  // Constant-evaluable ceil(log2); returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Show-ahead synchronous FIFO, one per demux lane.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   push, din  : write din when push=1 and not full
//   pop        : advance the head when pop=1 and not empty
//   full/empty : occupancy flags
//   head       : current head entry; holds the last popped value while empty
module stream_fifo
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] last_q;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  // No bypass: a full FIFO refuses a push even if it pops this cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr];
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers and count
  // make stale entries unreachable, and a resettable array costs a lot.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // While empty, present the last value that left so the output does not
  // expose stale storage; last_q is cleared by reset so dout reads 0.
  assign head = empty ? last_q : mem[rd_ptr];

endmodule

// File: rtl/stream_demux.sv
// 1-to-2 valid/ready stream demultiplexer with per-lane FIFOs.
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   mode                : 0 = steer by din_sel, 1 = round-robin bursts
//   din/din_sel/din_valid/din_ready : input stream
//   dout_N/dout_N_valid/dout_N_ready: lane N output stream (N = 0, 1)
//   rr_lane             : current round-robin target lane; 0 while mode=0
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 2,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic [DATA_W-1:0] din,
  input  logic              din_sel,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [DATA_W-1:0] dout_0,
  output logic              dout_0_valid,
  input  logic              dout_0_ready,
  output logic [DATA_W-1:0] dout_1,
  output logic              dout_1_valid,
  input  logic              dout_1_ready,
  output logic              rr_lane
);

  localparam int CNT_W = (clog2(BURST_LEN) < 1) ? 1 : clog2(BURST_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  rr_state_t        state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             tgt;
  logic             tgt_full;
  logic             accept;
  logic             full_0, full_1;
  logic             empty_0, empty_1;

  // Lane selection and handshake; only the target lane gates din_ready.
  assign tgt       = mode ? rr_lane : din_sel;
  assign tgt_full  = (tgt == LANE1) ? full_1 : full_0;
  assign din_ready = !reset && !tgt_full;
  assign accept    = din_valid && din_ready;

  assign dout_0_valid = !empty_0;
  assign dout_1_valid = !empty_1;

  stream_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lane_0 (
    .clk   (clk),
    .reset (reset),
    .push  (accept && (tgt == LANE0)),
    .pop   (dout_0_ready),
    .din   (din),
    .full  (full_0),
    .empty (empty_0),
    .head  (dout_0)
  );

  stream_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lane_1 (
    .clk   (clk),
    .reset (reset),
    .push  (accept && (tgt == LANE1)),
    .pop   (dout_1_ready),
    .din   (din),
    .full  (full_1),
    .empty (empty_1),
    .head  (dout_1)
  );

  // Round-robin FSM: state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RR_LANE0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Round-robin FSM: next state. Held at a fresh lane-0 burst outside mode 1;
  // a stalled (unaccepted) beat leaves both state and count untouched.
  // NOTE: every combinational output gets a default first so no path through
  // the block leaves it unassigned and infers a latch.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    if (!mode) begin
      state_d    = RR_LANE0;
      beat_cnt_d = '0;
    end else if (accept) begin
      if (beat_cnt_q == CNT_LAST) begin
        state_d    = (state_q == RR_LANE0) ? RR_LANE1 : RR_LANE0;
        beat_cnt_d = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
  end

  // Round-robin FSM: output. Masked by mode so mode 0 always reads lane 0.
  always_comb begin
    rr_lane = 1'b0;
    if (mode && (state_q == RR_LANE1)) rr_lane = 1'b1;
  end

endmodule
